// File: rtl/ceespu_fetch_pkg.sv
// ceespu_fetch_pkg: shared widths, constants and types for the fetch stage.
//   PC_W / INSTR_W    : word-address and instruction widths
//   NOP_INSTR         : bubble instruction (ADD c0, write-disabled)
//   DEFAULT_RESET_PC  : default first fetch address
//   fetch_entry_t     : prefetch buffer entry {pc, instr}
//   pc_inc            : 25-bit wrapping PC increment
package ceespu_fetch_pkg;

    localparam int PC_W    = 25;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0;
    localparam logic [PC_W-1:0]    DEFAULT_RESET_PC = 25'd0;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + 25'd1;
    endfunction

endpackage

// File: rtl/ceespu_fetch_if.sv
// ceespu_fetch_if: pipelined instruction-memory request/response bus.
//   imem_en     : request valid (fetch -> memory)
//   imem_addr   : request word address (fetch -> memory)
//   imem_ready  : memory accepts the request this cycle
//   imem_rvalid : response valid, in order, at least one cycle after acceptance
//   imem_data   : response instruction word
// master = fetch stage, slave = instruction memory.
interface ceespu_fetch_if;
    import ceespu_fetch_pkg::*;

    logic               imem_en;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ready;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_data;

    modport master (
        output imem_en, imem_addr,
        input  imem_ready, imem_rvalid, imem_data
    );

    modport slave (
        input  imem_en, imem_addr,
        output imem_ready, imem_rvalid, imem_data
    );

endinterface

// File: rtl/ceespu_fetch_fifo.sv
// ceespu_fetch_fifo: prefetch buffer between memory responses and the
// decoder output register.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data
//   pop        : consume head (ignored when nothing is available)
//   clear      : drop all stored entries (redirect)
//   push_data  : incoming entry
//   head       : oldest entry, or push_data when empty (bypass)
//   avail      : head is meaningful this cycle
//   count      : stored entries (bypassed words are never stored)
module ceespu_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 57
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           head,
    output logic                       avail,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             empty;
    logic             bypass;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign avail   = !empty || push;
    assign head    = empty ? push_data : mem[rd_ptr];
    // A word arriving into an empty buffer while the consumer is ready
    // passes straight through and never occupies a slot.
    assign bypass  = pop && push && empty;
    assign do_push = push && !bypass;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

    // The issue credit rule upstream makes overflow impossible.
    always @(posedge clk) begin
        if (!rst && !clear) assert (!(do_push && !do_pop && count == FULL));
    end

endmodule

// File: rtl/ceespu_fetch.sv
// ceespu_fetch: instruction fetch stage feeding the decoder.
//   I_clk, I_rst     : clock, asynchronous active-high reset
//   I_stall          : hold all O_* outputs
//   I_branch         : redirect pulse (branch / interrupt vector)
//   I_branchTarget   : redirect word address
//   imem             : instruction-memory bus (master side)
//   O_instruction    : instruction word to decoder (NOP when bubble)
//   O_PC             : PC of O_instruction
//   O_valid          : O_instruction is a real fetched word
//   O_justBranched   : first valid word after a redirect
module ceespu_fetch
    import ceespu_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_stall,
    input  logic               I_branch,
    input  logic [PC_W-1:0]    I_branchTarget,
    ceespu_fetch_if.master     imem,
    output logic [INSTR_W-1:0] O_instruction,
    output logic [PC_W-1:0]    O_PC,
    output logic               O_valid,
    output logic               O_justBranched
);

    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_sum;
    logic            accept;
    logic            resp;
    logic            push;
    logic            pop;
    logic            avail;
    logic            pending_jb;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // Every outstanding request reserves a buffer slot, so the buffer
    // can always absorb all responses even under a long stall.
    assign credit_sum    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem.imem_en   = !I_rst && !I_branch && (credit_sum < DEPTH_C);
    assign imem.imem_addr = fetch_pc;

    assign accept = imem.imem_en && imem.imem_ready;
    // Responses with nothing outstanding (e.g. after a reset) are ignored.
    assign resp   = imem.imem_rvalid && (outstanding != '0);
    assign push   = resp && (drop == '0) && !I_branch;
    assign pop    = !I_stall && !I_branch;

    assign push_entry = '{pc: resp_pc, instr: imem.imem_data};

    ceespu_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (I_clk),
        .rst       (I_rst),
        .push      (push),
        .pop       (pop),
        .clear     (I_branch),
        .push_data (push_entry),
        .head      (head),
        .avail     (avail),
        .count     (fifo_count)
    );

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(resp);
            if (I_branch) begin
                fetch_pc <= I_branchTarget;
                resp_pc  <= I_branchTarget;
                // Everything still in flight after this cycle belongs to the old path.
                drop     <= outstanding + CW'(accept) - CW'(resp);
            end else begin
                if (accept) fetch_pc <= pc_inc(fetch_pc);
                if (resp) begin
                    if (drop != '0) drop <= drop - ONE;
                    else            resp_pc <= pc_inc(resp_pc);
                end
            end
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            O_instruction  <= NOP_INSTR;
            O_PC           <= '0;
            O_valid        <= 1'b0;
            O_justBranched <= 1'b0;
            pending_jb     <= 1'b0;
        end else if (I_branch) begin
            O_instruction  <= NOP_INSTR;
            O_valid        <= 1'b0;
            O_justBranched <= 1'b0;
            pending_jb     <= 1'b1;
        end else if (!I_stall) begin
            if (avail) begin
                O_instruction  <= head.instr;
                O_PC           <= head.pc;
                O_valid        <= 1'b1;
                O_justBranched <= pending_jb;
                pending_jb     <= 1'b0;
            end else begin
                O_instruction  <= NOP_INSTR;
                O_valid        <= 1'b0;
                O_justBranched <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ceespu_fetch.sv
// tb_ceespu_fetch: directed + randomized bench for ceespu_fetch with an
// in-order memory model and a PC-sequence scoreboard.
module tb_ceespu_fetch;
    import ceespu_fetch_pkg::*;

    localparam logic [24:0] RST_PC = 25'h10;
    localparam int          DEPTH  = 2;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        stall  = 1'b0;
    logic        branch = 1'b0;
    logic [24:0] target = '0;
    logic [31:0] o_instr;
    logic [24:0] o_pc;
    logic        o_valid;
    logic        o_jb;

    ceespu_fetch_if bus ();

    ceespu_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .I_clk          (clk),
        .I_rst          (rst),
        .I_stall        (stall),
        .I_branch       (branch),
        .I_branchTarget (target),
        .imem           (bus),
        .O_instruction  (o_instr),
        .O_PC           (o_pc),
        .O_valid        (o_valid),
        .O_justBranched (o_jb)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [24:0] a);
        return {7'b0, a} ^ 32'hA5A50000;
    endfunction

    // ---------------- memory model: in-order, fixed latency ----------------
    logic        mem_off  = 1'b0;
    logic        inj_rv   = 1'b0;
    logic        inj_rdy  = 1'b0;
    logic [31:0] inj_data = '0;
    logic        rdy_rand = 1'b0;
    logic        mdl_rv   = 1'b0;
    logic        mdl_rdy  = 1'b1;
    logic [31:0] mdl_data = '0;
    int          mem_delay = 1;
    logic [24:0] q_addr[$];
    int          q_due[$];
    int          cyc = 0;

    assign bus.imem_ready  = mem_off ? inj_rdy  : mdl_rdy;
    assign bus.imem_rvalid = mem_off ? inj_rv   : mdl_rv;
    assign bus.imem_data   = mem_off ? inj_data : mdl_data;

    initial begin : memory
        logic        acc;
        logic        con;
        logic [24:0] a;
        forever begin
            @(negedge clk);
            acc = bus.imem_en && bus.imem_ready && !mem_off;
            con = mdl_rv && !mem_off;
            a   = bus.imem_addr;
            @(posedge clk);
            #1;
            cyc++;
            if (mem_off) begin
                q_addr.delete();
                q_due.delete();
            end else begin
                if (con) begin
                    void'(q_addr.pop_front());
                    void'(q_due.pop_front());
                end
                if (acc) begin
                    q_addr.push_back(a);
                    q_due.push_back(cyc + mem_delay - 1);
                    check("outstanding_le_depth", q_addr.size() <= DEPTH, 1'b1);
                end
            end
            mdl_rdy = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
            if (!mem_off && q_addr.size() > 0 && q_due[0] <= cyc) begin
                mdl_rv   = 1'b1;
                mdl_data = word_at(q_addr[0]);
            end else begin
                mdl_rv   = 1'b0;
                mdl_data = '0;
            end
        end
    end

    // ---------------- scoreboard: expected PC stream ----------------
    logic [24:0] exp_pc  = RST_PC;
    logic        exp_jb  = 1'b0;
    int          n_words = 0;

    initial begin : scoreboard
        logic        was_stall;
        logic        was_branch;
        logic [24:0] was_target;
        was_stall  = 1'b1;
        was_branch = 1'b0;
        was_target = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_pc     = RST_PC;
                exp_jb     = 1'b0;
                was_stall  = 1'b1;
                was_branch = 1'b0;
            end else begin
                if (was_branch) begin
                    check("sb_branch_bubble", o_valid, 1'b0);
                    exp_pc = was_target;
                    exp_jb = 1'b1;
                end else if (!was_stall) begin
                    if (o_valid) begin
                        check("sb_pc", o_pc, exp_pc);
                        check("sb_instr", o_instr, word_at(exp_pc));
                        check("sb_jb", o_jb, exp_jb);
                        exp_pc = exp_pc + 25'd1;
                        exp_jb = 1'b0;
                        n_words++;
                    end else begin
                        check("sb_bubble_instr", o_instr, 32'h0);
                        check("sb_bubble_jb", o_jb, 1'b0);
                    end
                end
                was_stall  = stall;
                was_branch = branch;
                was_target = target;
            end
        end
    end

    task automatic wait_word(input string tag, input int budget, output bit got);
        int start;
        start = n_words;
        got   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (n_words != start) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_arrived"}, got, 1'b1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin : stimulus
        logic [31:0] ci;
        logic [24:0] cp;
        logic        cv;
        logic        cj;
        bit          got;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", o_valid, 1'b0);
        check("rst_instr", o_instr, 32'h0);
        check("rst_pc", o_pc, 25'h0);
        check("rst_jb", o_jb, 1'b0);
        check("rst_en", bus.imem_en, 1'b0);

        // 1: stream from RESET_PC, first valid in third cycle after release
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk); #1;
        check("t1_en", bus.imem_en, 1'b1);
        check("t1_addr", bus.imem_addr, RST_PC);
        check("t1_valid_c1", o_valid, 1'b0);
        @(negedge clk); #1;
        check("t1_valid_c2", o_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("t1_valid_stream", o_valid, 1'b1);
            check("t1_pc_stream", o_pc, RST_PC + 25'(i));
        end

        // 2: stall four cycles, outputs frozen, credit limit respected
        @(posedge clk); #2 stall = 1'b1;
        @(negedge clk); #1;
        ci = o_instr; cp = o_pc; cv = o_valid; cj = o_jb;
        if (bus.imem_en) check("t2_credit", (bus.imem_addr - exp_pc) < 25'(DEPTH), 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("t2_hold_instr", o_instr, ci);
            check("t2_hold_pc", o_pc, cp);
            check("t2_hold_valid", o_valid, cv);
            check("t2_hold_jb", o_jb, cj);
            if (bus.imem_en) check("t2_credit", (bus.imem_addr - exp_pc) < 25'(DEPTH), 1'b1);
        end
        check("t2_no_request_when_full", bus.imem_en, 1'b0);
        @(posedge clk); #2 stall = 1'b0;
        @(negedge clk); #1;
        check("t2_hold_pc_last", o_pc, cp);
        for (int i = 0; i < 4; i++) wait_word("t2_resume", 20, got);

        // 3: redirect with two requests outstanding
        mem_delay = 2;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #2;
            if (q_addr.size() == DEPTH) begin
                got = 1'b1;
                break;
            end
        end
        check("t3_two_outstanding", got, 1'b1);
        branch = 1'b1; target = 25'h200;
        @(posedge clk); #2 branch = 1'b0;
        wait_word("t3_first", 40, got);
        check("t3_pc_first", o_pc, 25'h200);
        check("t3_jb_first", o_jb, 1'b1);
        wait_word("t3_second", 40, got);
        check("t3_pc_second", o_pc, 25'h201);
        check("t3_jb_second", o_jb, 1'b0);

        // 4: redirect coinciding with a response and a stall
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #2;
            if (bus.imem_rvalid) begin
                got = 1'b1;
                break;
            end
        end
        check("t4_rvalid_seen", got, 1'b1);
        stall = 1'b1; branch = 1'b1; target = 25'h280;
        @(posedge clk); #2 branch = 1'b0;
        @(negedge clk); #1;
        check("t4_valid_after", o_valid, 1'b0);
        check("t4_instr_after", o_instr, 32'h0);
        @(posedge clk); #2 stall = 1'b0;
        wait_word("t4_first", 40, got);
        check("t4_pc_first", o_pc, 25'h280);
        check("t4_jb_first", o_jb, 1'b1);

        // back-to-back redirects
        @(posedge clk); #2 branch = 1'b1; target = 25'h300;
        @(posedge clk); #2 target = 25'h400;
        @(posedge clk); #2 branch = 1'b0;
        wait_word("bb_first", 40, got);
        check("bb_pc_first", o_pc, 25'h400);
        check("bb_jb_first", o_jb, 1'b1);

        // 5: random ready, stalls and redirects
        rdy_rand = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #2;
            stall  = ($urandom_range(3, 0) == 0);
            branch = ($urandom_range(31, 0) == 0);
            if (branch) target = 25'($urandom);
        end
        @(posedge clk); #2 stall = 1'b0; branch = 1'b0;
        rdy_rand = 1'b0;
        for (int i = 0; i < 3; i++) wait_word("t5_tail", 40, got);

        // 6: async reset with a response in flight
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #2;
            if (q_addr.size() > 0) begin
                got = 1'b1;
                break;
            end
        end
        check("t6_inflight", got, 1'b1);
        #1 rst = 1'b1; mem_off = 1'b1; inj_rv = 1'b0; inj_rdy = 1'b0;
        #1;
        check("t6_rst_valid", o_valid, 1'b0);
        check("t6_rst_instr", o_instr, 32'h0);
        check("t6_rst_pc", o_pc, 25'h0);
        check("t6_rst_jb", o_jb, 1'b0);
        check("t6_rst_en", bus.imem_en, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0; inj_rv = 1'b1; inj_data = 32'hDEADBEEF; inj_rdy = 1'b0;
        @(posedge clk); #2 inj_rv = 1'b0; mem_off = 1'b0;
        wait_word("t6_first", 40, got);
        check("t6_pc_first", o_pc, RST_PC);
        check("t6_instr_first", o_instr, word_at(RST_PC));
        check("t6_jb_first", o_jb, 1'b0);

        // PC wrap at the top of the address space
        @(posedge clk); #2 branch = 1'b1; target = 25'h1FFFFFF;
        @(posedge clk); #2 branch = 1'b0;
        wait_word("wrap_first", 40, got);
        check("wrap_pc_top", o_pc, 25'h1FFFFFF);
        check("wrap_jb_top", o_jb, 1'b1);
        wait_word("wrap_second", 40, got);
        check("wrap_pc_zero", o_pc, 25'h0);
        check("wrap_jb_zero", o_jb, 1'b0);

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
